// File: rtl/kernel_host_pkg.sv
// rtl/kernel_host_pkg.sv - shared state encoding and default parameters for kernel_host
package kernel_host_pkg;

    localparam int DEF_DEPTH   = 2;
    localparam int DEF_ADDR_W  = 1;
    localparam int DEF_DATA_W  = 1;
    localparam int DEF_RES_W   = 2;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        RD_ADDR,
        RD_WAIT,
        UNLOAD,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/kernel_host_if.sv
// rtl/kernel_host_if.sv - kernel start/done and array control bundle
interface kernel_host_if
    import kernel_host_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RES_W  = DEF_RES_W
);
    logic              kern_r_enable;
    logic              kern_init;
    logic              kern_w_enable;
    logic [RES_W-1:0]  kern_result;
    logic              kern_controlArr;
    logic              kern_arrWEnable;
    logic [ADDR_W-1:0] kern_arrAddr;
    logic [DATA_W-1:0] kern_arrWData;
    logic [DATA_W-1:0] kern_arrRData;

    // host side drives the kernel controls and array port
    modport host (
        output kern_r_enable, kern_init, kern_controlArr, kern_arrWEnable,
               kern_arrAddr, kern_arrWData,
        input  kern_w_enable, kern_result, kern_arrRData
    );

    // kernel side answers with done, result and read data
    modport kernel (
        input  kern_r_enable, kern_init, kern_controlArr, kern_arrWEnable,
               kern_arrAddr, kern_arrWData,
        output kern_w_enable, kern_result, kern_arrRData
    );
endinterface

// File: rtl/kernel_host_timer.sv
// rtl/kernel_host_timer.sv - kernel completion watchdog counter
module kernel_host_timer
    import kernel_host_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt;

    assign expire = (cnt == TW'(TIMEOUT - 1));

    // count while enabled, saturating at the expiry value
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + TW'(1);
        end
    end
endmodule

// File: rtl/kernel_host.sv
// rtl/kernel_host.sv - loads kernel array, starts kernel, waits for done, unloads array
module kernel_host
    import kernel_host_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RES_W   = DEF_RES_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              init_val,
    output logic              busy,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ul_valid,
    input  logic              ul_ready,
    output logic [DATA_W-1:0] ul_data,
    output logic              ul_last,
    output logic              res_valid,
    output logic [RES_W-1:0]  result,
    output logic              timeout_err,
    kernel_host_if.host       kif
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic              init_q;
    logic              at_last;
    logic              tmr_expire;

    assign at_last           = (cnt == LAST_ADDR);
    assign busy              = (state != IDLE);
    assign kif.kern_arrAddr  = cnt;
    assign kif.kern_arrWData = ld_data;

    kernel_host_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == START),
        .enable (state == RUN),
        .expire (tmr_expire)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state and per-state control outputs
    always_comb begin
        state_nx            = state;
        ld_ready            = 1'b0;
        ul_valid            = 1'b0;
        ul_last             = 1'b0;
        res_valid           = 1'b0;
        kif.kern_r_enable   = 1'b0;
        kif.kern_init       = 1'b0;
        kif.kern_controlArr = 1'b0;
        kif.kern_arrWEnable = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                ld_ready            = 1'b1;
                kif.kern_controlArr = 1'b1;
                kif.kern_arrWEnable = ld_valid;
                if (ld_valid && at_last) state_nx = START;
            end
            START: begin
                kif.kern_r_enable = 1'b1;
                kif.kern_init     = init_q;
                state_nx          = RUN;
            end
            RUN: begin
                if (kif.kern_w_enable)  state_nx = RD_ADDR;
                else if (tmr_expire)    state_nx = ERR;
            end
            RD_ADDR: begin
                kif.kern_controlArr = 1'b1;
                state_nx            = RD_WAIT;
            end
            RD_WAIT: begin
                state_nx = UNLOAD;
            end
            UNLOAD: begin
                ul_valid = 1'b1;
                ul_last  = at_last;
                if (ul_ready) state_nx = at_last ? DONE : RD_ADDR;
            end
            DONE: begin
                res_valid = 1'b1;
                state_nx  = IDLE;
            end
            ERR: begin
                state_nx = ERR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // address counter, captured init value, result, unload data and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            init_q      <= 1'b0;
            result      <= '0;
            ul_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        init_q <= init_val;
                        cnt    <= '0;
                    end
                end
                LOAD: begin
                    if (ld_valid && !at_last) cnt <= cnt + ADDR_W'(1);
                end
                RUN: begin
                    if (kif.kern_w_enable) begin
                        result <= kif.kern_result;
                        cnt    <= '0;
                    end else if (tmr_expire) begin
                        timeout_err <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    ul_data <= kif.kern_arrRData;
                end
                UNLOAD: begin
                    if (ul_ready && !at_last) cnt <= cnt + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_kernel_host.sv
// tb/tb_kernel_host.sv - randomized self-checking bench for kernel_host
module tb_kernel_host;
    localparam int DEPTH   = 2;
    localparam int ADDR_W  = 1;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 8;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, init_val = 1'b0;
    logic       busy, ld_ready, ul_valid, ul_last, res_valid, timeout_err;
    logic       ld_valid = 1'b0, ul_ready = 1'b0;
    logic [7:0] ld_data = 8'h00, ul_data, result;
    int         tests_run = 0, tests_failed = 0;

    kernel_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W)) kif ();

    kernel_host #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .init_val(init_val), .busy(busy),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ul_valid(ul_valid), .ul_ready(ul_ready), .ul_data(ul_data), .ul_last(ul_last),
        .res_valid(res_valid), .result(result), .timeout_err(timeout_err), .kif(kif)
    );

    always #5 clk = ~clk;

    // behavioural kernel: plain memory, result = init + sum of words, done after kern_lat cycles
    logic [7:0] mem [DEPTH] = '{default: 8'h00};
    int         wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         rd_cnt = 0, ren_cnt = 0, viol = 0, kern_lat = 2, lat_k = 0;
    bit         kern_hang = 0, force_done = 0, busy_k = 0;
    logic       init_k = 1'b0, k_done = 1'b0;
    logic [7:0] k_res = 8'h00, k_rdata = 8'h00;

    assign kif.kern_w_enable = k_done;
    assign kif.kern_result   = k_res;
    assign kif.kern_arrRData = k_rdata;

    always @(posedge clk) begin
        if (kif.kern_controlArr && kif.kern_arrWEnable) begin
            mem[kif.kern_arrAddr] <= kif.kern_arrWData;
            wr_addr_q.push_back(int'(kif.kern_arrAddr));
            wr_data_q.push_back(kif.kern_arrWData);
        end
        if (kif.kern_controlArr && !kif.kern_arrWEnable && !ld_ready) begin
            k_rdata <= mem[kif.kern_arrAddr];
            rd_cnt  <= rd_cnt + 1;
        end
        if ((kif.kern_r_enable && kif.kern_controlArr) || (kif.kern_arrWEnable && !kif.kern_controlArr))
            viol <= viol + 1;
        if (kif.kern_r_enable) begin
            ren_cnt <= ren_cnt + 1;
            init_k  <= kif.kern_init;
        end
        if (force_done) begin
            k_done <= 1'b1;
            k_res  <= 8'hEE;
            busy_k <= 0;
        end else if (kif.kern_r_enable) begin
            k_done <= 1'b0;
            busy_k <= 1;
            lat_k  <= kern_lat;
        end else if (busy_k && !kern_hang) begin
            if (lat_k == 0) begin
                k_done <= 1'b1;
                k_res  <= {7'd0, init_k} + mem[0] + mem[1];
                busy_k <= 0;
            end else begin
                lat_k <= lat_k - 1;
            end
        end
    end

    // drives one full job; returns what the unload stream and status port delivered
    task automatic do_job(input logic init, input logic [7:0] w0, input logic [7:0] w1, input int bp0,
                          output logic [7:0] u0, output logic [7:0] u1, output logic l0, output logic l1,
                          output int nw, output logic [7:0] res, output int unstable,
                          output int min_gap, output bit ok);
        logic [7:0] hold;
        int stall, need, last_cyc;
        u0 = 'x; u1 = 'x; l0 = 'x; l1 = 'x; res = 'x; hold = 'x;
        nw = 0; unstable = 0; min_gap = 1000; ok = 0; stall = 0; need = bp0; last_cyc = -1;
        @(negedge clk); start = 1'b1; init_val = init;
        @(negedge clk); start = 1'b0; init_val = $urandom_range(0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ld_valid = 1'b1; ld_data = (i == 0) ? w0 : w1;
            @(negedge clk); ld_valid = 1'b0; ld_data = 8'($urandom);
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (res_valid === 1'b1) begin res = result; ok = 1; break; end
            if (ul_valid === 1'b1) begin
                if (stall == 0) hold = ul_data;
                else if (ul_data !== hold) unstable++;
                if (stall >= need) begin
                    ul_ready = 1'b1;
                    if (nw == 0) begin u0 = ul_data; l0 = ul_last; end
                    else begin u1 = ul_data; l1 = ul_last; end
                    if (last_cyc >= 0 && cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
                    last_cyc = cyc; nw++; stall = 0; need = $urandom_range(0, 2);
                end else begin
                    stall++;
                end
            end else begin
                ul_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk); ul_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        tests_run++;
        if ({busy, ld_ready, ul_valid, ul_last, res_valid, timeout_err, kif.kern_r_enable,
             kif.kern_controlArr, kif.kern_arrWEnable} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b want 000000000", {busy, ld_ready, ul_valid, ul_last, res_valid,
                     timeout_err, kif.kern_r_enable, kif.kern_controlArr, kif.kern_arrWEnable});
        end
        tests_run++;
        if (result !== 8'h00 || ul_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data result=%h ul_data=%h want 00 00", result, ul_data);
        end
    endtask

    task automatic test_basic();
        logic [7:0] u0, u1, res; logic l0, l1; int nw, uns, gap, wsnap, rsnap; bit ok;
        kern_lat = 2; wsnap = wr_addr_q.size(); rsnap = ren_cnt;
        do_job(1'b1, 8'd1, 8'd0, 0, u0, u1, l0, l1, nw, res, uns, gap, ok);
        tests_run++;
        if (wr_addr_q.size() != wsnap + 2 || wr_addr_q[wsnap] != 0 || wr_addr_q[wsnap+1] != 1 ||
            wr_data_q[wsnap] !== 8'd1 || wr_data_q[wsnap+1] !== 8'd0) begin
            tests_failed++;
            $display("FAIL basic_writes got %0d writes want addr 0,1 data 1,0", wr_addr_q.size() - wsnap);
        end
        tests_run++;
        if (ren_cnt - rsnap != 1 || init_k !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_start pulses=%0d init=%b want 1 1", ren_cnt - rsnap, init_k);
        end
        tests_run++;
        if (!ok || nw != 2 || u0 !== 8'd1 || u1 !== 8'd0 || l0 !== 1'b0 || l1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_unload ok=%0d n=%0d data=%h,%h last=%b%b want 1 2 01,00 01", ok, nw, u0, u1, l0, l1);
        end
        tests_run++;
        if (res !== 8'd2) begin tests_failed++; $display("FAIL basic_result got %h want 02", res); end
        tests_run++;
        if (gap < 3 || viol != 0) begin
            tests_failed++;
            $display("FAIL basic_spacing gap=%0d viol=%0d want >=3 0", gap, viol);
        end
    endtask

    task automatic test_random();
        logic [7:0] w0, w1, u0, u1, res, exp_res; logic init, l0, l1; int nw, uns, gap; bit ok;
        for (int j = 0; j < 8; j++) begin
            init = 1'($urandom_range(0, 1)); w0 = 8'($urandom); w1 = 8'($urandom);
            kern_lat = $urandom_range(0, 5);
            exp_res = 8'(int'(init) + int'(w0) + int'(w1));
            do_job(init, w0, w1, $urandom_range(0, 3), u0, u1, l0, l1, nw, res, uns, gap, ok);
            tests_run++;
            if (!ok || nw != 2 || u0 !== w0 || u1 !== w1 || {l0, l1} !== 2'b01 || res !== exp_res || uns != 0) begin
                tests_failed++;
                $display("FAIL random_job%0d ok=%0d n=%0d data=%h,%h last=%b%b res=%h want 2 %h,%h 01 %h",
                         j, ok, nw, u0, u1, l0, l1, res, w0, w1, exp_res);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] u0, u1, res; logic l0, l1; int nw, uns, gap, rsnap; bit ok;
        kern_lat = 1; rsnap = rd_cnt;
        do_job(1'b0, 8'hA5, 8'h3C, 5, u0, u1, l0, l1, nw, res, uns, gap, ok);
        tests_run++;
        if (uns != 0 || u0 !== 8'hA5) begin
            tests_failed++;
            $display("FAIL bp_stable changes=%0d word0=%h want 0 a5", uns, u0);
        end
        tests_run++;
        if (rd_cnt - rsnap != 2 || nw != 2 || u1 !== 8'h3C) begin
            tests_failed++;
            $display("FAIL bp_count reads=%0d words=%0d want 2 2", rd_cnt - rsnap, nw);
        end
    endtask

    task automatic test_stale_done();
        logic [7:0] u0, u1, res; logic l0, l1; int nw, uns, gap; bit ok;
        @(negedge clk); force_done = 1;
        @(negedge clk); force_done = 0;
        kern_lat = 4;
        do_job(1'b1, 8'h10, 8'h20, 0, u0, u1, l0, l1, nw, res, uns, gap, ok);
        tests_run++;
        if (!ok || res !== 8'h31 || u0 !== 8'h10 || u1 !== 8'h20) begin
            tests_failed++;
            $display("FAIL stale_done ok=%0d res=%h data=%h,%h want 1 31 10,20", ok, res, u0, u1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] u0, u1, r1, r2; logic l0, l1; int nw, uns, gap; bit ok1, ok2;
        kern_lat = 0;
        do_job(1'b0, 8'h05, 8'h06, 0, u0, u1, l0, l1, nw, r1, uns, gap, ok1);
        do_job(1'b1, 8'h40, 8'h02, 1, u0, u1, l0, l1, nw, r2, uns, gap, ok2);
        tests_run++;
        if (!ok1 || r1 !== 8'h0B) begin tests_failed++; $display("FAIL b2b_first ok=%0d res=%h want 1 0b", ok1, r1); end
        tests_run++;
        if (!ok2 || r2 !== 8'h43 || result !== 8'h43 || u0 !== 8'h40 || u1 !== 8'h02) begin
            tests_failed++;
            $display("FAIL b2b_second ok=%0d res=%h held=%h want 1 43 43", ok2, r2, result);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] u0, u1, res; logic l0, l1; int nw, uns, gap, wsnap; bit ok;
        @(negedge clk); start = 1'b1; init_val = 1'b0;
        @(negedge clk); start = 1'b0; ld_valid = 1'b1; ld_data = 8'h77;
        @(negedge clk); ld_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        tests_run++;
        if ({busy, ld_ready, ul_valid, ul_last, res_valid, timeout_err, kif.kern_r_enable,
             kif.kern_controlArr, kif.kern_arrWEnable} !== 9'b0 || result !== 8'h00 || ul_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL midload_reset ctrl=%b result=%h ul_data=%h want 0 00 00", {busy, ld_ready, ul_valid,
                     ul_last, res_valid, timeout_err, kif.kern_r_enable, kif.kern_controlArr, kif.kern_arrWEnable},
                     result, ul_data);
        end
        kern_lat = 1; wsnap = wr_addr_q.size();
        do_job(1'b0, 8'h12, 8'h34, 0, u0, u1, l0, l1, nw, res, uns, gap, ok);
        tests_run++;
        if (wr_addr_q.size() != wsnap + 2 || wr_addr_q[wsnap] != 0 || !ok || res !== 8'h46 || u0 !== 8'h12) begin
            tests_failed++;
            $display("FAIL midload_restart ok=%0d res=%h word0=%h want 1 46 12", ok, res, u0);
        end
    endtask

    task automatic test_timeout();
        int n; bit seen;
        kern_hang = 1;
        @(negedge clk); start = 1'b1; init_val = 1'b1;
        @(negedge clk); start = 1'b0; ld_valid = 1'b1; ld_data = 8'h11;
        @(negedge clk); ld_data = 8'h22;
        @(negedge clk); ld_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (kif.kern_r_enable === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL timeout_start got no kern_r_enable want pulse"); end
        n = 0;
        @(negedge clk); #1;
        while (timeout_err !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (n != TIMEOUT || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_delay got %0d cycles busy=%b want %0d 1", n, busy, TIMEOUT);
        end
        @(negedge clk); start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0; #1;
        tests_run++;
        if (ld_ready !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_sticky ld_ready=%b busy=%b err=%b want 0 1 1", ld_ready, busy, timeout_err);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        tests_run++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_clear err=%b busy=%b want 0 0", timeout_err, busy);
        end
        kern_hang = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_stale_done();
        test_back_to_back();
        test_reset_mid_load();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
